// File: rtl/codec_pkg.sv
// Shared constants for the codec serial audio link: default word/slot widths,
// receive FSM state encodings and channel select codes.
package codec_pkg;

    localparam int CODEC_DATA_W = 24;
    localparam int CODEC_SLOT_W = 32;

    localparam logic [1:0] RX_WAIT_FRAME = 2'd0;
    localparam logic [1:0] RX_DELAY      = 2'd1;
    localparam logic [1:0] RX_SHIFT      = 2'd2;
    localparam logic [1:0] RX_PAD        = 2'd3;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = RX_WAIT_FRAME,
        ST_DELAY      = RX_DELAY,
        ST_SHIFT      = RX_SHIFT,
        ST_PAD        = RX_PAD
    } rx_state_t;

endpackage

// File: rtl/codec_edge_sync.sv
// Multi-stage synchronizer for a slow serial-link signal sampled in the clk
// domain, with registered single-cycle rise/fall pulses on the synced copy.
module codec_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the input through the synchronizer and compare against the previous synced value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/codec_adc_rx.sv
// I2S receive deserializer: turns the codec ADC serial stream (SDTI) framed by
// BCLK/LRCK into 24-bit left/right words, reported together once per frame.
// Optional frame-length checking is enabled by defining CODEC_ADC_RX_FRAME_CHECK_EN,
// which adds FRAME_ERR and ERR_CNT outputs.
module codec_adc_rx
    import codec_pkg::*;
#(
    parameter int DATA_W      = CODEC_DATA_W,
    parameter int SLOT_W      = CODEC_SLOT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BCLK,
    input  logic              LRCK,
    input  logic              SDTI,
    output logic [DATA_W-1:0] LCH_ADC,
    output logic [DATA_W-1:0] RCH_ADC,
    output logic              ADC_VALID
`ifdef CODEC_ADC_RX_FRAME_CHECK_EN
    ,
    output logic              FRAME_ERR,
    output logic [7:0]        ERR_CNT
`endif
);

    localparam int IDX_W = $clog2(SLOT_W + 1);

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic lrck_lvl, lr_rise, lr_fall, lr_edge;
    logic sync_unused;

    logic [SYNC_STAGES-1:0] sdti_q;
    logic                   sdti_s;

    rx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_in, aligned;
    logic              ch_q, ch_d;
    logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
    logic [DATA_W-1:0] lch_d, rch_d;
    logic              valid_d;

    codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (BCLK),
        .dout (bclk_lvl),
        .rise (bclk_rise),
        .fall (bclk_fall)
    );

    codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (LRCK),
        .dout (lrck_lvl),
        .rise (lr_rise),
        .fall (lr_fall)
    );

    // Only BCLK rises matter; its level and fall pulse are not used.
    assign sync_unused = bclk_lvl ^ bclk_fall;

    // SDTI synchronizer of the same depth, so data stays aligned with the BCLK rise pulse.
    always_ff @(posedge clk) begin
        if (!rst) sdti_q <= '0;
        else      sdti_q <= {sdti_q[SYNC_STAGES-2:0], SDTI};
    end

    assign sdti_s   = sdti_q[SYNC_STAGES-1];
    assign lr_edge  = lr_rise | lr_fall;
    assign shift_in = {shift_q[DATA_W-2:0], sdti_s};
    // Bits received so far, moved up to the MSB end with zero-filled LSBs.
    assign aligned  = shift_q << (DATA_W - int'(bit_idx_q));

    // State, counters, holding and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_WAIT_FRAME;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ch_q      <= CH_LEFT;
            left_q    <= '0;
            right_q   <= '0;
            LCH_ADC   <= '0;
            RCH_ADC   <= '0;
            ADC_VALID <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ch_q      <= ch_d;
            left_q    <= left_d;
            right_q   <= right_d;
            LCH_ADC   <= lch_d;
            RCH_ADC   <= rch_d;
            ADC_VALID <= valid_d;
        end
    end

    // Next-state logic: LRCK edges take priority over a same-cycle BCLK rise,
    // and that rise becomes the delay bit of the half just started.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        ch_d      = ch_q;
        left_d    = left_q;
        right_d   = right_q;
        lch_d     = LCH_ADC;
        rch_d     = RCH_ADC;
        valid_d   = 1'b0;

        case (state_q)
            ST_WAIT_FRAME: begin
                if (lr_fall) begin
                    ch_d      = CH_LEFT;
                    bit_idx_d = '0;
                    shift_d   = '0;
                    state_d   = bclk_rise ? ST_SHIFT : ST_DELAY;
                end
            end
            default: begin
                if (lr_edge) begin
                    // Close the current half; in PAD the word is already latched.
                    if (state_q != ST_PAD) begin
                        if (ch_q == CH_LEFT) left_d  = aligned;
                        else                 right_d = aligned;
                    end
                    if (lr_fall && (ch_q == CH_RIGHT)) begin
                        valid_d = 1'b1;
                        lch_d   = left_q;
                        rch_d   = (state_q == ST_PAD) ? right_q : aligned;
                    end
                    ch_d      = lrck_lvl ? CH_RIGHT : CH_LEFT;
                    bit_idx_d = '0;
                    shift_d   = '0;
                    state_d   = bclk_rise ? ST_SHIFT : ST_DELAY;
                end else if (bclk_rise) begin
                    case (state_q)
                        ST_DELAY: state_d = ST_SHIFT;
                        ST_SHIFT: begin
                            shift_d   = shift_in;
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                            if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                                if (ch_q == CH_LEFT) left_d  = shift_in;
                                else                 right_d = shift_in;
                                state_d = ST_PAD;
                            end
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase
    end

`ifdef CODEC_ADC_RX_FRAME_CHECK_EN
    logic [IDX_W-1:0] slot_q;
    logic             err_q;
    logic [7:0]       cnt_q;

    // Count BCLK rises per half (delay bit included) and flag halves of the wrong length.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (lr_edge && (state_q != ST_WAIT_FRAME) && (slot_q != IDX_W'(SLOT_W))) begin
                err_q <= 1'b1;
                if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            end
            if (lr_edge && ((state_q != ST_WAIT_FRAME) || lr_fall))
                slot_q <= bclk_rise ? IDX_W'(1) : '0;
            else if (bclk_rise && (state_q != ST_WAIT_FRAME) && (slot_q != '1))
                slot_q <= slot_q + IDX_W'(1);
        end
    end

    assign FRAME_ERR = err_q;
    assign ERR_CNT   = cnt_q;
`endif

endmodule
